// File: rtl/fifo_burst_reader_if.sv
// rtl/fifo_burst_reader_if.sv - FIFO read port and output beat stream bundle for fifo_burst_reader
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    // Reader side: consumes the FIFO head, produces the beat stream
    modport master (
        input  fifo_empty, fifo_data, fifo_count, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    // Environment side: the FIFO and the downstream consumer
    modport slave (
        output fifo_empty, fifo_data, fifo_count, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - bursty drainer of a show-ahead FIFO onto a registered valid/ready stream; optional FIFO_RD_TIMEOUT_EN
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    fifo_burst_reader_if.master bus,
    output logic                busy,
    output logic [15:0]         burst_count
);
    localparam int BL_W = $clog2(BURST_LEN + 1);

    localparam logic [ADDR_WIDTH:0] C_BURST_CNT  = (ADDR_WIDTH + 1)'(BURST_LEN);
    localparam logic [BL_W-1:0]     C_BEATS_FULL = BL_W'(BURST_LEN);
    localparam logic [BL_W-1:0]     C_BEATS_ONE  = BL_W'(1);

    // Reject configurations the burst counter and timer cannot represent
    if (BURST_LEN < 1 || BURST_LEN > DEPTH || TIMEOUT < 2) begin : g_bad_params
        $error("fifo_burst_reader: BURST_LEN must be 1..DEPTH and TIMEOUT >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BL_W-1:0]       r_beats_left;
    logic                  r_flush_pend;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic [15:0]           r_burst_count;
    logic                  w_rd_en;
    logic                  w_start_full;
    logic                  w_start_part;
    logic                  w_accept;
    logic                  w_timeout_hit;

    assign w_accept = r_m_valid && bus.m_ready;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] C_TMR_HIT = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] r_idle_timer;

    // Count idle cycles while a partial burst sits in the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_timer <= '0;
        end else if (r_state == IDLE && bus.fifo_count != '0 && bus.fifo_count < C_BURST_CNT) begin
            r_idle_timer <= r_idle_timer + 1'b1;
        end else begin
            r_idle_timer <= '0;
        end
    end

    assign w_timeout_hit = (r_idle_timer == C_TMR_HIT);
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst start decisions, pop strobe and next state
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_en      = 1'b0;
        w_start_full = 1'b0;
        w_start_part = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fifo_count >= C_BURST_CNT) begin
                    w_start_full = 1'b1;
                    w_state_nxt  = BURST;
                end else if ((r_flush_pend || flush || w_timeout_hit) && bus.fifo_count != '0) begin
                    w_start_part = 1'b1;
                    w_state_nxt  = BURST;
                end
            end
            BURST: begin
                w_rd_en = (r_beats_left != '0) && !bus.fifo_empty && (!r_m_valid || bus.m_ready);
                if (w_accept && r_m_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output beat register, beat budget, flush latch and burst counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beats_left  <= '0;
            r_flush_pend  <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_last      <= 1'b0;
            r_burst_count <= '0;
        end else begin
            // A new flush request outranks clearing so it is never lost
            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if (r_state == IDLE &&
                         (bus.fifo_count == '0 ||
                          ((w_start_full || w_start_part) && bus.fifo_count <= C_BURST_CNT))) begin
                r_flush_pend <= 1'b0;
            end

            if (w_start_full) begin
                r_beats_left <= C_BEATS_FULL;
            end else if (w_start_part) begin
                r_beats_left <= BL_W'(bus.fifo_count);
            end else if (w_rd_en) begin
                r_beats_left <= r_beats_left - 1'b1;
            end

            if (w_rd_en) begin
                r_m_data  <= bus.fifo_data;
                r_m_valid <= 1'b1;
                r_m_last  <= (r_beats_left == C_BEATS_ONE);
            end else if (w_accept) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end

            if (r_state == BURST && w_accept && r_m_last) begin
                r_burst_count <= r_burst_count + 16'd1;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_data     = r_m_data;
    assign bus.m_last     = r_m_last;
    assign busy           = (r_state == BURST);
    assign burst_count    = r_burst_count;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BL    = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] burst_count;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_burst_reader #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT(64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus.master),
        .busy        (busy),
        .burst_count (burst_count)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model feeding the reader
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp = '0;
    logic [AW-1:0] rp = '0;
    logic [AW:0]   cnt = '0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          ready = 1'b1;
    int            underflow = 0;

    assign bus.fifo_empty = (cnt == '0);
    assign bus.fifo_data  = mem[rp];
    assign bus.fifo_count = cnt;
    assign bus.m_ready    = ready;

    always @(posedge clk) begin
        logic pop;
        pop = bus.fifo_rd_en && (cnt != '0);
        if (bus.fifo_rd_en && cnt == '0) underflow <= underflow + 1;
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end

    // Accepted-beat monitor: {last, data}
    logic [8:0] beats [$];
    always @(posedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) beats.push_back({bus.m_last, bus.m_data});
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; one word written per clock
    task automatic write_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int n, input logic [7:0] base, input int blen);
        logic [8:0] exp_beat;
        check({tag, "_nbeats"}, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            exp_beat = {((i % blen) == blen - 1), base + 8'(i)};
            check($sformatf("%s_beat%0d", tag, i), beats[i], exp_beat);
        end
        beats.delete();
    endtask

    initial begin
        int waited;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_burst_count", burst_count, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: one full burst, two-cycle latency
        write_words(4, 8'hA0);
        check("t1_n0_valid", bus.m_valid, 0);
        check("t1_n0_busy", busy, 0);
        @(negedge clk);
        check("t1_n1_busy", busy, 1);
        check("t1_n1_valid", bus.m_valid, 0);
        @(negedge clk);
        check("t1_n2_valid", bus.m_valid, 1);
        check("t1_n2_data", bus.m_data, 8'hA0);
        repeat (4) @(negedge clk);
        check("t1_busy_end", busy, 0);
        check("t1_burst_count", burst_count, 1);
        check_beats("t1", 4, 8'hA0, 4);

        // T2: ten words -> two full bursts, two words left behind
        write_words(10, 8'hB0);
        repeat (30) @(negedge clk);
        check_beats("t2", 8, 8'hB0, 4);
        check("t2_fifo_count", bus.fifo_count, 2);
        check("t2_busy", busy, 0);
        check("t2_burst_count", burst_count, 3);

        // T3: backpressure mid-burst
        write_words(2, 8'hBA);
        @(negedge clk);
        @(negedge clk);
        check("t3_first_valid", bus.m_valid, 1);
        check("t3_first_data", bus.m_data, 8'hB8);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t3_hold_valid%0d", k), bus.m_valid, 1);
            check($sformatf("t3_hold_data%0d", k), bus.m_data, 8'hB8);
            check($sformatf("t3_hold_rd_en%0d", k), bus.fifo_rd_en, 0);
        end
        ready = 1'b1;
        repeat (10) @(negedge clk);
        check_beats("t3", 4, 8'hB8, 4);
        check("t3_burst_count", burst_count, 4);

        // T4: partial burst by flush, then flush with empty FIFO
        write_words(3, 8'hD0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (10) @(negedge clk);
        check_beats("t4", 3, 8'hD0, 3);
        check("t4_burst_count", burst_count, 5);
        check("t4_fifo_count", bus.fifo_count, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (5) @(negedge clk);
        check("t4e_nbeats", beats.size(), 0);
        check("t4e_busy", busy, 0);
        check("t4e_flush_pend", dut.r_flush_pend, 0);
        check("t4e_burst_count", burst_count, 5);

        // T5: idle partial burst
        write_words(2, 8'hE0);
`ifdef FIFO_RD_TIMEOUT_EN
        waited = 0;
        while (!bus.m_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("t5_timeout_latency", waited, 64);
        repeat (8) @(negedge clk);
        check_beats("t5", 2, 8'hE0, 2);
`else
        waited = 0;
        repeat (200) @(negedge clk);
        check("t5_no_beats", beats.size() + waited, 0);
        check("t5_fifo_count", bus.fifo_count, 2);
        check("t5_busy", busy, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (8) @(negedge clk);
        check_beats("t5", 2, 8'hE0, 2);
`endif
        check("t5_burst_count", burst_count, 6);

        // T6: asynchronous reset during beat 2
        write_words(4, 8'hF0);
        repeat (3) @(negedge clk);
        check("t6_beat2_data", bus.m_data, 8'hF1);
        check("t6_beat2_valid", bus.m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.m_valid, 0);
        check("t6_rst_last", bus.m_last, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_burst_count", burst_count, 0);
        check("t6_rst_rd_en", bus.fifo_rd_en, 0);

        check("no_underflow", underflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
